// File: rtl/aes_key_expand_seq_if.sv
// Handshake and key bus between an AES key-schedule requester and aes_key_expand_seq.
// The cache_hit signal exists only when AES_KEYEXP_CACHE_EN is defined.
interface aes_key_expand_seq_if;
  logic          start;
  logic [127:0]  key;
  logic          busy;
  logic          done;
  logic          key_valid;
  logic [1407:0] expanded_key;
`ifdef AES_KEYEXP_CACHE_EN
  logic          cache_hit;
`endif

  modport master (
    output start,
    output key,
    input  busy,
    input  done,
    input  key_valid,
`ifdef AES_KEYEXP_CACHE_EN
    input  cache_hit,
`endif
    input  expanded_key
  );

  modport slave (
    input  start,
    input  key,
    output busy,
    output done,
    output key_valid,
`ifdef AES_KEYEXP_CACHE_EN
    output cache_hit,
`endif
    output expanded_key
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule producing RKPC round keys per clock into a packed 11-key bus.
// Defining AES_KEYEXP_CACHE_EN skips re-expansion when the same key is requested again.
module aes_key_expand_seq #(
  parameter int RKPC = 1
) (
  input  logic                clk,
  input  logic                rst,
  aes_key_expand_seq_if.slave kx
);

  if (!(RKPC == 1 || RKPC == 2 || RKPC == 5)) begin : g_bad_rkpc
    $error("aes_key_expand_seq: RKPC must be 1, 2 or 5");
  end

  localparam logic [3:0] RKPC_W   = 4'(RKPC);
  localparam logic [3:0] LAST_RND = 4'(11 - RKPC);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t                 state;
  logic                   busy_q;
  logic                   done_q;
  logic                   key_valid_q;
  logic [1407:0]          ek_q;
  logic [127:0]           work_q;
  logic [3:0]             rnd_q;
  logic [7:0]             rcon_q;
  logic [RKPC-1:0][127:0] rk_next;
  logic [7:0]             rcon_next;
  logic                   hit_now;

`ifdef AES_KEYEXP_CACHE_EN
  logic [127:0] last_key_q;
  logic         last_ok_q;
  logic         cache_hit_q;

  assign hit_now      = last_ok_q && (kx.key == last_key_q);
  assign kx.cache_hit = cache_hit_q;
`else
  assign hit_now = 1'b0;
`endif

  // Chain RKPC rounds from the working register within one cycle.
  always_comb begin
    logic [127:0] rk_w;
    logic [7:0]   rc_w;
    rk_next = '0;
    rk_w    = work_q;
    rc_w    = rcon_q;
    for (int i = 0; i < RKPC; i++) begin
      rk_w       = next_round_key(rk_w, rc_w);
      rk_next[i] = rk_w;
      rc_w       = xtime(rc_w);
    end
    rcon_next = rc_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      ek_q        <= '0;
      rnd_q       <= 4'd0;
      rcon_q      <= 8'h01;
`ifdef AES_KEYEXP_CACHE_EN
      last_key_q  <= '0;
      last_ok_q   <= 1'b0;
      cache_hit_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef AES_KEYEXP_CACHE_EN
      cache_hit_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (kx.start && hit_now) begin
            // Schedule for this key is already on the bus; just acknowledge.
            done_q <= 1'b1;
`ifdef AES_KEYEXP_CACHE_EN
            cache_hit_q <= 1'b1;
`endif
          end else if (kx.start) begin
            ek_q[127:0] <= kx.key;
            work_q      <= kx.key;
            key_valid_q <= 1'b0;
            rnd_q       <= 4'd1;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b1;
            state       <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 0; i < RKPC; i++) begin
            ek_q[128*(int'(rnd_q) + i) +: 128] <= rk_next[i];
          end
          work_q <= rk_next[RKPC-1];
          rcon_q <= rcon_next;
          rnd_q  <= rnd_q + RKPC_W;
          if (rnd_q == LAST_RND) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            key_valid_q <= 1'b1;
`ifdef AES_KEYEXP_CACHE_EN
            last_key_q  <= ek_q[127:0];
            last_ok_q   <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kx.busy         = busy_q;
  assign kx.done         = done_q;
  assign kx.key_valid    = key_valid_q;
  assign kx.expanded_key = ek_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for aes_key_expand_seq: three instances (RKPC 1, 2, 5) against a FIPS-197 style model.
// Honours AES_KEYEXP_CACHE_EN when defined.
module tb_aes_key_expand_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expand_seq_if if1();
  aes_key_expand_seq_if if2();
  aes_key_expand_seq_if if5();

  aes_key_expand_seq #(.RKPC(1)) dut1 (.clk(clk), .rst(rst), .kx(if1.slave));
  aes_key_expand_seq #(.RKPC(2)) dut2 (.clk(clk), .rst(rst), .kx(if2.slave));
  aes_key_expand_seq #(.RKPC(5)) dut5 (.clk(clk), .rst(rst), .kx(if5.slave));

  typedef struct {
    logic [1407:0] ek;
    int            issue;
    int            lat;
    int            bcyc;
    bit            hit;
    bit            fixed;
    logic [127:0]  rk1;
    logic [127:0]  rk10;
  } exp_t;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  exp_t         q[3][$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           bcnt[3];
  bit           last_ok[3];
  logic [127:0] last_key[3];
  logic [7:0]   sb[256];
  bit           fx_en = 1'b0;
  logic [127:0] fx_rk1, fx_rk10;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rk_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 5);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int x = 1; x < 256; x++)
        if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[b] = s;
    end
  endtask

  function automatic logic [1407:0] model_sched(input logic [127:0] k);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] r = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int rr = 0; rr < 11; rr++)
      r[128*rr +: 128] = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
    return r;
  endfunction

  task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut_rkpc=%0d actual=%h required=%h", name, rk_of(d), act, req);
    end
  endtask

  task automatic mon(input int d, input logic busy, input logic done, input logic kv,
                     input logic hit, input logic [1407:0] ek);
    exp_t e;
    if (busy) bcnt[d]++;
    if (busy && done) chk("busy_done_overlap", d, 128'(busy & done), 128'd0);
    if (done) begin
      if (q[d].size() == 0) begin
        chk("unexpected_done", d, 128'd1, 128'd0);
      end else begin
        e = q[d].pop_front();
        chk("done_latency", d, 128'(cyc - e.issue), 128'(e.lat));
        chk("busy_cycles", d, 128'(bcnt[d]), 128'(e.bcyc));
        chk("key_valid_at_done", d, 128'(kv), 128'd1);
        for (int r = 0; r < 11; r++)
          chk($sformatf("round_key_%0d", r), d, ek[128*r +: 128], e.ek[128*r +: 128]);
`ifdef AES_KEYEXP_CACHE_EN
        chk("cache_hit", d, 128'(hit), 128'(e.hit));
`endif
        if (e.fixed) begin
          chk("fixed_rk1", d, ek[255:128], e.rk1);
          chk("fixed_rk10", d, ek[1407:1280], e.rk10);
        end
      end
      bcnt[d] = 0;
    end
    if (hit && !done) chk("cache_hit_without_done", d, 128'(hit), 128'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
`ifdef AES_KEYEXP_CACHE_EN
      mon(0, if1.busy, if1.done, if1.key_valid, if1.cache_hit, if1.expanded_key);
      mon(1, if2.busy, if2.done, if2.key_valid, if2.cache_hit, if2.expanded_key);
      mon(2, if5.busy, if5.done, if5.key_valid, if5.cache_hit, if5.expanded_key);
`else
      mon(0, if1.busy, if1.done, if1.key_valid, 1'b0, if1.expanded_key);
      mon(1, if2.busy, if2.done, if2.key_valid, 1'b0, if2.expanded_key);
      mon(2, if5.busy, if5.done, if5.key_valid, 1'b0, if5.expanded_key);
`endif
    end
  end

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble_keys();
    if1.key = rand_key();
    if2.key = rand_key();
    if5.key = rand_key();
  endtask

  // Called at a falling edge; the following rising edge is E0 for every selected instance.
  task automatic issue(input logic [127:0] k, input bit [2:0] mask);
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (mask[d]) begin
        e.hit = 1'b0;
`ifdef AES_KEYEXP_CACHE_EN
        e.hit = last_ok[d] && (last_key[d] == k);
`endif
        e.ek    = model_sched(k);
        e.issue = cyc;
        e.lat   = e.hit ? 1 : 1 + 10 / rk_of(d);
        e.bcyc  = e.hit ? 0 : 10 / rk_of(d);
        e.fixed = fx_en;
        e.rk1   = fx_rk1;
        e.rk10  = fx_rk10;
        q[d].push_back(e);
        last_ok[d]  = 1'b1;
        last_key[d] = k;
      end
    end
    if1.start = mask[0]; if1.key = k;
    if2.start = mask[1]; if2.key = k;
    if5.start = mask[2]; if5.key = k;
    @(negedge clk);
    if1.start = 1'b0;
    if2.start = 1'b0;
    if5.start = 1'b0;
    scramble_keys();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 200) begin
      @(negedge clk);
      scramble_keys();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_done_timeout pending=%0d required=0", q[0].size() + q[1].size() + q[2].size());
      for (int d = 0; d < 3; d++) q[d].delete();
    end
    @(negedge clk);
  endtask

  task automatic zero_chk(input int d, input logic busy, input logic done, input logic kv,
                          input logic [1407:0] ek);
    chk("reset_busy", d, 128'(busy), 128'd0);
    chk("reset_done", d, 128'(done), 128'd0);
    chk("reset_key_valid", d, 128'(kv), 128'd0);
    chk("reset_expanded_key_nonzero", d, 128'(|ek), 128'd0);
  endtask

  task automatic zero_all();
    zero_chk(0, if1.busy, if1.done, if1.key_valid, if1.expanded_key);
    zero_chk(1, if2.busy, if2.done, if2.key_valid, if2.expanded_key);
    zero_chk(2, if5.busy, if5.done, if5.key_valid, if5.expanded_key);
  endtask

  initial begin
    logic [127:0] k, prev;
    for (int d = 0; d < 3; d++) begin
      bcnt[d] = 0; last_ok[d] = 1'b0; last_key[d] = '0;
    end
    build_sbox();
    fx_rk1 = '0; fx_rk10 = '0;

    // Reset held two edges with start asserted.
    rst = 1'b1;
    if1.start = 1'b1; if2.start = 1'b1; if5.start = 1'b1;
    scramble_keys();
    @(negedge clk); zero_all();
    @(negedge clk); zero_all();
    if1.start = 1'b0; if2.start = 1'b0; if5.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Known-answer schedules.
    fx_en = 1'b1; fx_rk1 = FIPS_RK1; fx_rk10 = FIPS_RK10;
    issue(FIPS_KEY, 3'b111);
    fx_en = 1'b0;
    wait_idle();
    fx_en = 1'b1; fx_rk1 = ZERO_RK1; fx_rk10 = ZERO_RK10;
    issue(128'd0, 3'b111);
    fx_en = 1'b0;
    wait_idle();

    // Start pulse with another key while the RKPC=1 instance is busy.
    issue(rand_key(), 3'b111);
    @(negedge clk);
    @(negedge clk);
    if1.start = 1'b1; if1.key = '0;
    @(negedge clk);
    if1.start = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);

    // Reset sampled on the 5th EXPAND edge of the RKPC=1 instance.
    issue(FIPS_KEY, 3'b111);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    zero_all();
    for (int d = 0; d < 3; d++) begin
      q[d].delete(); last_ok[d] = 1'b0; bcnt[d] = 0;
    end
    rst = 1'b0;
    @(negedge clk);

    // Clean run, then the same key again, then a different key.
    fx_en = 1'b1; fx_rk1 = FIPS_RK1; fx_rk10 = FIPS_RK10;
    issue(FIPS_KEY, 3'b111);
    wait_idle();
    issue(FIPS_KEY, 3'b111);
    fx_en = 1'b0;
    wait_idle();
    issue(rand_key(), 3'b111);
    wait_idle();

    // Random keys, sometimes repeating the previous one.
    prev = rand_key();
    for (int it = 0; it < 20; it++) begin
      k = ($urandom_range(3) == 0) ? prev : rand_key();
      issue(k, 3'b111);
      wait_idle();
      prev = k;
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
